// File: rtl/key_event_array.sv
// key_event_array: N-channel push-button conditioner.
// Each key is synchronised, debounced and tracked by a small IDLE/PRESSED/HELD
// FSM that produces one-cycle press, release, long-press and auto-repeat pulses.
module key_event_array #(
   parameter int N_KEYS       = 4,
   parameter int ACTIVE_LOW   = 1,
   parameter int DEBOUNCE_CYC = 120000,
   parameter int LONG_CYC     = 6000000,
   parameter int REPEAT_CYC   = 1200000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [N_KEYS-1:0] i_keys,
   input  logic [N_KEYS-1:0] i_repeat_en,
   output logic [N_KEYS-1:0] o_level,
   output logic [N_KEYS-1:0] o_press,
   output logic [N_KEYS-1:0] o_release,
   output logic [N_KEYS-1:0] o_long,
   output logic [N_KEYS-1:0] o_repeat
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int HOLD_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
   localparam int REP_W  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);

   // Raw pin value that means "not pressed"; synchronisers reset to it so a
   // key held through reset is seen as a fresh press afterwards.
   localparam logic RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      HELD
   } state_t;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      logic              sync_a;
      logic              sync_b;
      logic              pressed;
      logic [DB_W-1:0]   db_cnt;
      logic              level;
      logic              accept;
      logic              accept_press;
      logic              accept_release;

      state_t            state;
      state_t            state_next;
      logic [HOLD_W-1:0] hold_cnt;
      logic [HOLD_W-1:0] hold_next;
      logic [REP_W-1:0]  rep_cnt;
      logic [REP_W-1:0]  rep_next;
      logic              press_q;
      logic              press_next;
      logic              release_q;
      logic              release_next;
      logic              long_q;
      logic              long_next;
      logic              repeat_q;
      logic              repeat_next;

      // Two-flop synchroniser bringing the asynchronous pin into the clock domain.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            sync_a <= RAW_IDLE;
            sync_b <= RAW_IDLE;
         end else begin
            sync_a <= i_keys[k];
            sync_b <= sync_a;
         end
      end

      assign pressed        = (ACTIVE_LOW != 0) ? ~sync_b : sync_b;
      assign accept         = (pressed != level) && (db_cnt == DB_LAST);
      assign accept_press   = accept & pressed;
      assign accept_release = accept & ~pressed;

      // Debounce: a level change is accepted only after DEBOUNCE_CYC consecutive differing cycles.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
         end else if (pressed == level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            level  <= pressed;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end

      // Next-state and pulse decode; a release always beats a long/repeat threshold.
      always_comb begin
         state_next   = state;
         hold_next    = hold_cnt;
         rep_next     = rep_cnt;
         press_next   = 1'b0;
         release_next = 1'b0;
         long_next    = 1'b0;
         repeat_next  = 1'b0;
         case (state)
            IDLE: begin
               if (accept_press) begin
                  state_next = PRESSED;
                  press_next = 1'b1;
                  hold_next  = '0;
               end
            end
            PRESSED: begin
               if (accept_release) begin
                  state_next   = IDLE;
                  release_next = 1'b1;
                  hold_next    = '0;
                  rep_next     = '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state_next = HELD;
                  long_next  = 1'b1;
                  rep_next   = '0;
               end else begin
                  hold_next = hold_cnt + 1'b1;
               end
            end
            HELD: begin
               if (accept_release) begin
                  state_next   = IDLE;
                  release_next = 1'b1;
                  hold_next    = '0;
                  rep_next     = '0;
               end else if (rep_cnt == REP_LAST) begin
                  rep_next    = '0;
                  repeat_next = i_repeat_en[k];
               end else begin
                  rep_next = rep_cnt + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               hold_next  = '0;
               rep_next   = '0;
            end
         endcase
      end

      // FSM state, hold/repeat counters and registered one-cycle pulses.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            rep_cnt   <= rep_next;
            press_q   <= press_next;
            release_q <= release_next;
            long_q    <= long_next;
            repeat_q  <= repeat_next;
         end
      end

      assign o_level[k]   = level;
      assign o_press[k]   = press_q;
      assign o_release[k] = release_q;
      assign o_long[k]    = long_q;
      assign o_repeat[k]  = repeat_q;
   end

endmodule

// File: tb/tb_key_event_array.sv
// tb_key_event_array: directed vector table plus hand-written sequences for
// the release/long race and reset in the middle of a hold.
module tb_key_event_array;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] keys = 4'b1111;
   logic [3:0] rep_en = 4'b0000;
   logic [3:0] level;
   logic [3:0] press;
   logic [3:0] rel;
   logic [3:0] lng;
   logic [3:0] rpt;

   int checks = 0;
   int errors = 0;

   key_event_array #(
      .N_KEYS      (4),
      .ACTIVE_LOW  (1),
      .DEBOUNCE_CYC(4),
      .LONG_CYC    (20),
      .REPEAT_CYC  (5)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_keys     (keys),
      .i_repeat_en(rep_en),
      .o_level    (level),
      .o_press    (press),
      .o_release  (rel),
      .o_long     (lng),
      .o_repeat   (rpt)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   typedef struct {
      string      tag;
      logic [3:0] keys;
      logic [3:0] rep_en;
      int         wait_cyc;
      logic [3:0] level;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] lng;
      logic [3:0] rpt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string tag, input logic [3:0] k, input logic [3:0] r,
                               input int w, input logic [3:0] lv, input logic [3:0] pr,
                               input logic [3:0] rl, input logic [3:0] lg, input logic [3:0] rp);
      vec_t v;
      v.tag = tag; v.keys = k; v.rep_en = r; v.wait_cyc = w;
      v.level = lv; v.press = pr; v.rel = rl; v.lng = lg; v.rpt = rp;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] k, input logic [3:0] r);
      keys   = k;
      rep_en = r;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] lv, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] lg, input logic [3:0] rp);
      checks++;
      if ({level, press, rel, lng, rpt} !== {lv, pr, rl, lg, rp}) begin
         errors++;
         $display("[TB] FAIL %s: got level=%b press=%b release=%b long=%b repeat=%b, want level=%b press=%b release=%b long=%b repeat=%b",
                  tag, level, press, rel, lng, rpt, lv, pr, rl, lg, rp);
      end
   endtask

   task automatic checkQuiet(input string tag);
      checks++;
      if ({press, rel, lng, rpt} !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL %s: unexpected pulse press=%b release=%b long=%b repeat=%b, want all 0000",
                  tag, press, rel, lng, rpt);
      end
   endtask

   task automatic runQuiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         checkQuiet(tag);
      end
   endtask

   // Main sequence: reset, vector table, then the multi-cycle corner cases.
   initial begin
      vecs.push_back(mk("clean_press",      4'b1110, 4'b0000, 6,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk("press_single",     4'b1110, 4'b0000, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk("clean_release",    4'b1111, 4'b0000, 6,  4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000));
      vecs.push_back(mk("multi_press",      4'b0110, 4'b0000, 6,  4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk("multi_release",    4'b1111, 4'b0000, 6,  4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000));
      vecs.push_back(mk("idle",             4'b1111, 4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      for (int b = 0; b < 6; b++) begin
         vecs.push_back(mk("bounce", (b % 2 == 0) ? 4'b1101 : 4'b1111, 4'b0000, 2,
                           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      end
      vecs.push_back(mk("bounce_press",     4'b1101, 4'b0000, 6,  4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk("bounce_release",   4'b1111, 4'b0000, 6,  4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
      vecs.push_back(mk("rep_press",        4'b1011, 4'b0100, 6,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk("rep_long",         4'b1011, 4'b0100, 20, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000));
      for (int r = 0; r < 4; r++) begin
         vecs.push_back(mk("rep_pulse",     4'b1011, 4'b0100, 5,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100));
      end
      vecs.push_back(mk("rep_gap",          4'b1011, 4'b0100, 4,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk("rep_last",         4'b1111, 4'b0100, 1,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100));
      vecs.push_back(mk("rep_release_wins", 4'b1111, 4'b0100, 5,  4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
      vecs.push_back(mk("norep_press",      4'b1011, 4'b0000, 6,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk("norep_long",       4'b1011, 4'b0000, 20, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000));
      vecs.push_back(mk("norep_quiet",      4'b1011, 4'b0000, 15, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk("norep_release",    4'b1111, 4'b0000, 6,  4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000));

      applyStimulus(4'b1111, 4'b0000);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].keys, vecs[i].rep_en);
         for (int c = 1; c < vecs[i].wait_cyc; c++) begin
            tick();
            checkQuiet(vecs[i].tag);
         end
         tick();
         checkOutput(vecs[i].tag, vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].lng, vecs[i].rpt);
      end

      // Release accepted on exactly the cycle the long threshold would fire.
      applyStimulus(4'b1011, 4'b0000);
      runQuiet("race_debounce", 5);
      tick();
      checkOutput("race_press", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      runQuiet("race_hold", 14);
      applyStimulus(4'b1111, 4'b0000);
      runQuiet("race_pending", 5);
      tick();
      checkOutput("race_release_wins", 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      runQuiet("race_no_long", 10);

      // Reset while KEY0 is in HELD with the key still down afterwards.
      applyStimulus(4'b1110, 4'b0001);
      runQuiet("rst_debounce", 5);
      tick();
      checkOutput("rst_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      runQuiet("rst_hold", 19);
      tick();
      checkOutput("rst_long", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      runQuiet("rst_held", 2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_clear", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("rst_held_low", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("rst_redebounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      tick();
      checkOutput("rst_repress", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      applyStimulus(4'b1111, 4'b0000);
      runQuiet("rst_release_wait", 5);
      tick();
      checkOutput("rst_release", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
